lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter N, default 26, meaning LFSR state width in bits.
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning consecutive matches needed to lock.
REQ-003 SHALL have parameter LOSS_CNT, default 4, meaning consecutive mismatches while locked that drop lock.
REQ-004 SHALL have parameter ERR_W, default 16, meaning error counter width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 load  input  1  generator is being reseeded; forces resynchronisation.
REQ-009 valid  input  1  data holds a new generator state this cycle.
REQ-010 data  input  N  parallel generator state q[N-1:0].
REQ-011 clear_count  input  1  synchronous clear of err_count.
REQ-012 locked  output  1  checker is synchronised to the sequence.
REQ-013 error  output  1  one-cycle pulse per mismatched sample while locked.
REQ-014 err_count  output  ERR_W  saturating count of locked mismatches.
REQ-015 zero_state  output  1  last captured sample in HUNT was all-zero (lockup state).

Function
REQ-016 SHALL define step(p): nxt[0]=p[N-1]; nxt[i]=p[i-1]^p[N-1] for i in {1,2,6}; nxt[i]=p[i-1] for all other i.
REQ-017 SHALL hold an N-bit reference register ref and a three-state FSM: HUNT, VERIFY, LOCKED.
REQ-018 SHALL act only on cycles with valid=1; with valid=0 and load=0, all state, counters and outputs hold, except error, which is 0.
REQ-019 load=1 SHALL move the FSM to HUNT next cycle, clear the match and miss counters, and deassert locked, with priority over valid; err_count is kept.
REQ-020 HUNT, valid: ref<=data; if data==0, zero_state<=1 and the FSM stays in HUNT; else zero_state<=0, match_cnt<=0, and the FSM goes to VERIFY.
REQ-021 VERIFY, valid, data==step(ref): ref<=data, match_cnt+1; on reaching LOCK_CNT, the FSM goes to LOCKED and locked<=1.
REQ-022 VERIFY, valid, mismatch: ref<=data, match_cnt<=0, and the FSM stays in VERIFY; no error pulse and no count.
REQ-023 LOCKED, valid: ref<=step(ref) regardless of data (flywheel); a single error SHALL NOT reseed ref.
REQ-024 LOCKED match: miss_cnt<=0. Mismatch: error<=1 for one cycle, err_count+1, miss_cnt+1.
REQ-025 Mismatch that brings miss_cnt to LOSS_CNT: the FSM goes to HUNT, locked<=0, miss_cnt<=0; that mismatch is still counted and pulsed.
REQ-026 All outputs SHALL be registered; response latency is one clock after the sampling edge.
REQ-027 err_count SHALL saturate at 2^ERR_W-1.
REQ-028 clear_count SHALL win over a simultaneous increment (result 0).
REQ-029 Comparison SHALL be on all N bits.
REQ-030 Sequence wrap-around needs no special handling beyond step().

Reset
REQ-031 reset low SHALL immediately force: FSM=HUNT, ref=0, match_cnt=0, miss_cnt=0, locked=0, error=0, err_count=0, zero_state=0.
REQ-032 Reset asserted mid-lock SHALL discard lock state; after release the checker re-acquires from HUNT.
REQ-033 Release of reset SHALL be synchronous to clk; first action is on the first valid edge after release.

Verification
REQ-034 Assert reset mid-run with locked=1 and err_count=3 -> all outputs 0 asynchronously, before the next clk edge.
REQ-035 From HUNT, valid words 0x0000001, 0x0000002, 0x0000004, 0x0000008, 0x0000010 -> locked=1 one cycle after the fifth word; error never asserted.
REQ-036 Locked with ref=0x2000000: data 0x0000047 -> no error. Instead data 0x0000046 -> error pulse, err_count=1, and the next expected word is 0x000008E.
REQ-037 Locked: four consecutive wrong words -> four error pulses, err_count+=4, locked=0 after the fourth, FSM in HUNT. A correct word between the bad words resets miss_cnt, and lock is kept.
REQ-038 HUNT: data=0x0000000 valid -> zero_state=1, locked stays 0. Then data=0x0000001 -> zero_state=0 and the FSM enters VERIFY.
REQ-039 err_count=0xFFFF plus a mismatch -> stays 0xFFFF with error pulse. Mismatch with clear_count same cycle -> 0. load during LOCKED -> locked=0 next cycle, err_count unchanged.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: tracks a parallel LFSR generator state stream.
// It acquires lock from consecutive step() matches. Once locked, it flywheels
// the reference and counts mismatched samples in a saturating counter.
module lfsr_checker #(
    parameter int N        = 26,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             valid,
    input  logic [N-1:0]     data,
    input  logic             clear_count,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_state
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_VAL = MW'(LOCK_CNT);
    localparam logic [LW-1:0] LOSS_VAL = LW'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t            state_reg;
    logic [N-1:0]      ref_reg;
    logic [MW-1:0]     match_cnt_reg;
    logic [LW-1:0]     miss_cnt_reg;
    logic              locked_reg;
    logic              error_reg;
    logic [ERR_W-1:0]  err_count_reg;
    logic              zero_state_reg;

    logic [N-1:0]      step_ref;
    logic [MW-1:0]     match_cnt_next;
    logic [LW-1:0]     miss_cnt_next;
    logic              data_match;
    logic              err_inc;

    // One generator step applied to the reference: shift left, with the
    // top bit fed back into bit 0 and XORed into taps 1, 2 and 6.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_step
            if (gi == 0) begin : g_fb
                assign step_ref[gi] = ref_reg[N-1];
            end else if (gi == 1 || gi == 2 || gi == 6) begin : g_tap
                assign step_ref[gi] = ref_reg[gi-1] ^ ref_reg[N-1];
            end else begin : g_shift
                assign step_ref[gi] = ref_reg[gi-1];
            end
        end
    endgenerate

    assign data_match     = (data == step_ref);
    assign match_cnt_next = match_cnt_reg + MW'(1);
    assign miss_cnt_next  = miss_cnt_reg + LW'(1);
    // Counted mismatches only happen on valid, non-reseed cycles while locked.
    assign err_inc        = valid && !load && (state_reg == ST_LOCKED) && !data_match;

    // Acquisition / tracking state machine with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_HUNT;
            ref_reg        <= '0;
            match_cnt_reg  <= '0;
            miss_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            error_reg      <= 1'b0;
            zero_state_reg <= 1'b0;
        end else begin
            error_reg <= 1'b0;
            if (load) begin
                // Generator reseeded: drop everything and re-hunt; ref is
                // overwritten by the first captured sample anyway.
                state_reg     <= ST_HUNT;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
                locked_reg    <= 1'b0;
            end else if (valid) begin
                case (state_reg)
                    ST_HUNT: begin
                        ref_reg <= data;
                        if (data == '0) begin
                            // All-zero is the LFSR lockup state: never a seed.
                            zero_state_reg <= 1'b1;
                        end else begin
                            zero_state_reg <= 1'b0;
                            match_cnt_reg  <= '0;
                            state_reg      <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        // Reseed from the stream on every sample while verifying.
                        ref_reg <= data;
                        if (data_match) begin
                            match_cnt_reg <= match_cnt_next;
                            if (match_cnt_next == LOCK_VAL) begin
                                state_reg  <= ST_LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            match_cnt_reg <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: isolated bit errors must not corrupt ref.
                        ref_reg <= step_ref;
                        if (data_match) begin
                            miss_cnt_reg <= '0;
                        end else begin
                            error_reg <= 1'b1;
                            if (miss_cnt_next == LOSS_VAL) begin
                                state_reg    <= ST_HUNT;
                                locked_reg   <= 1'b0;
                                miss_cnt_reg <= '0;
                            end else begin
                                miss_cnt_reg <= miss_cnt_next;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= ST_HUNT;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_reg <= '0;
        end else if (clear_count) begin
            err_count_reg <= '0;
        end else if (err_inc && !(&err_count_reg)) begin
            err_count_reg <= err_count_reg + ERR_W'(1);
        end
    end

    assign locked     = locked_reg;
    assign error      = error_reg;
    assign err_count  = err_count_reg;
    assign zero_state = zero_state_reg;

endmodule
